// File: rtl/wb_stage_buffered.sv
// Registered RV32IM write-back stage: load alignment/extension, output register,
// and a small FIFO that merges long-latency results into idle write-back slots.
module wb_stage_buffered #(
   parameter int RD_W       = 5,
   parameter int LATE_DEPTH = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            MEM_VALID,
   input  logic [2:0]      MEM_FUNC3,
   input  logic [1:0]      MEM_ADDR_LO,
   input  logic            MEM_WRITE_ENABLE,
   input  logic            MEM_DATA_MEM_SELECT,
   input  logic [31:0]     MEM_JAL_SELECTED,
   input  logic [31:0]     MEM_DATA_OUT,
   input  logic [RD_W-1:0] MEM_RD,
   input  logic            LATE_VALID,
   input  logic [RD_W-1:0] LATE_RD,
   input  logic [31:0]     LATE_DATA,
   output logic            LATE_READY,
   output logic            STALL_REQ,
   output logic            WB_WRITE_ENABLE,
   output logic [31:0]     WB_WRITE_DATA,
   output logic [RD_W-1:0] WB_RD
);

   localparam int CW = $clog2(LATE_DEPTH + 1);
   localparam int PW = (LATE_DEPTH > 1) ? $clog2(LATE_DEPTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(LATE_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(LATE_DEPTH - 1);

   logic [RD_W-1:0] fifo_rd   [LATE_DEPTH];
   logic [31:0]     fifo_data [LATE_DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;

   logic        full;
   logic        empty;
   logic        pw;
   logic        push;
   logic        pop;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_data;
   logic [31:0] pipe_data;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign pw    = MEM_VALID & MEM_WRITE_ENABLE & (MEM_RD != '0);

   // Writes to x0 are accepted from the late unit but never stored.
   assign push  = LATE_VALID & LATE_READY & (LATE_RD != '0);
   // The FIFO only wins the slot when the pipeline is idle or the FIFO is full.
   assign pop   = !empty & (!pw | full);

   assign LATE_READY = !full;
   assign STALL_REQ  = full & pw;

   always_comb begin
      byte_v = 8'(MEM_DATA_OUT >> {MEM_ADDR_LO, 3'b000});
      half_v = 16'(MEM_DATA_OUT >> {MEM_ADDR_LO[1], 4'b0000});
      case (MEM_FUNC3)
         3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
         3'b001:  load_data = {{16{half_v[15]}}, half_v};
         3'b100:  load_data = {24'b0, byte_v};
         3'b101:  load_data = {16'b0, half_v};
         default: load_data = MEM_DATA_OUT;
      endcase
      pipe_data = MEM_DATA_MEM_SELECT ? load_data : MEM_JAL_SELECTED;
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_rd[tail]   <= LATE_RD;
         fifo_data[tail] <= LATE_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         WB_WRITE_ENABLE <= 1'b0;
         WB_WRITE_DATA   <= '0;
         WB_RD           <= '0;
      end else begin
         if (push) tail <= next_ptr(tail);
         if (pop)  head <= next_ptr(head);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         if (pop) begin
            WB_WRITE_ENABLE <= 1'b1;
            WB_WRITE_DATA   <= fifo_data[head];
            WB_RD           <= fifo_rd[head];
         end else if (pw) begin
            WB_WRITE_ENABLE <= 1'b1;
            WB_WRITE_DATA   <= pipe_data;
            WB_RD           <= MEM_RD;
         end else begin
            WB_WRITE_ENABLE <= 1'b0;
         end
      end
   end

endmodule
